// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus transaction, byte lanes, load extension, stall.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        acc_valid,
    input  logic        MemREAD,
    input  logic [1:0]  MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        bus_err,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] tmo_cnt;
    logic        we_q;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;

    logic        is_store;
    logic        start;
    logic [1:0]  size;      // 0 = byte, 1 = half, 2 = word
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        mis;

    // Select the addressed lane and sign/zero-extend; unknown load types read the full word.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b100:  extend_load = {24'b0, b};
            3'b101:  extend_load = {16'b0, h};
            default: extend_load = word;
        endcase
    endfunction

    always_comb begin
        is_store = (MemWrite != 2'b00);
        start    = acc_valid & (MemREAD | is_store);
        if (is_store)
            size = MemWrite - 2'd1;
        else begin
            case (funct3[1:0])
                2'b00:   size = 2'd0;
                2'b01:   size = 2'd1;
                default: size = 2'd2;
            endcase
        end
        case (size)
            2'd0: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{store_data[7:0]}};
            end
            2'd1: begin
                be    = 4'b0011 << {addr[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        mis = ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'b00));
`else
        mis = 1'b0;
`endif
        stall = ((state == IDLE) && start) || (state == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            we_q      <= 1'b0;
            lane_q    <= '0;
            funct3_q  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            load_data <= '0;
            bus_err   <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        we_q     <= is_store;
                        lane_q   <= addr[1:0];
                        funct3_q <= funct3;
                        tmo_cnt  <= '0;
                        if (mis) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            misalign  <= 1'b1;
                            load_data <= '0;
                        end else begin
                            state     <= BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_be    <= be;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= wdata;
                        end
                    end
                end
                BUSY: begin
                    // An ack arriving in the timeout cycle still completes the access.
                    if (mem_ack || (tmo_cnt == TMO_LAST)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        bus_err   <= ~mem_ack;
                        load_data <= (mem_ack && !we_q) ? extend_load(mem_rdata, lane_q, funct3_q) : '0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    bus_err   <= 1'b0;
                    misalign  <= 1'b0;
                    load_data <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses
// checked against a byte-lane arithmetic model of the memory access rules.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int TMO = 4;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_valid;
    logic        MemREAD;
    logic [1:0]  MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        bus_err;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .acc_valid(acc_valid), .MemREAD(MemREAD),
        .MemWrite(MemWrite), .funct3(funct3), .addr(addr), .store_data(store_data),
        .stall(stall), .done(done), .load_data(load_data), .bus_err(bus_err),
        .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One complete access; ack_cycle = cycle (1-based) that mem_ack is raised, 0 = never.
    task automatic run_access(input logic rd, input logic [1:0] mw, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rdata, input int ack_cycle);
        bit          is_st, exp_mis, to;
        int          nbytes, off, k_end;
        logic [3:0]  e_be;
        logic [31:0] e_wd, mask, v, e_ld;

        is_st = (mw != 2'b00);
        if (is_st) nbytes = (mw == 2'd1) ? 1 : (mw == 2'd2) ? 2 : 4;
        else       nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off  = (nbytes == 1) ? int'(a % 4) : (nbytes == 2) ? int'((a % 4) / 2 * 2) : 0;
        e_be = 4'(((1 << nbytes) - 1) << off);
        e_wd = (nbytes == 1) ? sd[7:0] * 32'h01010101 :
               (nbytes == 2) ? sd[15:0] * 32'h00010001 : sd;
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * nbytes)) - 1);
        v    = (rdata >> (8 * off)) & mask;
        if (f3 <= 3'd1 && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
        exp_mis = TRAP && (((nbytes == 2) && a[0]) || ((nbytes == 4) && (a[1:0] != 2'b00)));
        to    = (ack_cycle == 0) || (ack_cycle > TMO);
        k_end = to ? TMO : ack_cycle;
        e_ld  = (is_st || to || exp_mis) ? 32'h0 : v;

        @(posedge clk); #1;
        acc_valid = 1'b1; MemREAD = rd; MemWrite = mw; funct3 = f3;
        addr = a; store_data = sd; mem_ack = 1'b0;
        @(negedge clk);
        chk("stall_c0", 32'(stall), 32'd1);
        chk("req_c0", 32'(mem_req), 32'd0);

        if (!exp_mis) begin
            for (int c = 1; c <= k_end; c++) begin
                @(posedge clk); #1;
                mem_ack   = (c == ack_cycle);
                mem_rdata = (c == ack_cycle) ? rdata : $urandom;
                @(negedge clk);
                chk("busy_req", 32'(mem_req), 32'd1);
                chk("busy_stall", 32'(stall), 32'd1);
                chk("busy_done", 32'(done), 32'd0);
                chk("busy_we", 32'(mem_we), 32'(is_st));
                chk("busy_be", 32'(mem_be), 32'(e_be));
                chk("busy_addr", mem_addr, {a[31:2], 2'b00});
                chk("busy_wdata", mem_wdata, e_wd);
            end
        end

        @(posedge clk); #1;
        mem_ack = 1'b0; acc_valid = 1'b0; MemREAD = 1'b0; MemWrite = 2'b00;
        @(negedge clk);
        chk("done", 32'(done), 32'd1);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_req", 32'(mem_req), 32'd0);
        chk("load_data", load_data, e_ld);
        chk("bus_err", 32'(bus_err), 32'(to && !exp_mis));
        chk("misalign", 32'(misalign), 32'(exp_mis));

        // Stray ack back in IDLE must not start or finish anything.
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_done2", 32'(done), 32'd0);
        chk("idle_req2", 32'(mem_req), 32'd0);
    endtask

    initial begin
        logic [2:0] f3_tab [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
        logic       rd;
        logic [1:0] mw;

        rst = 1'b1; acc_valid = 1'b0; MemREAD = 1'b0; MemWrite = 2'b00; funct3 = 3'b000;
        addr = '0; store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ld", load_data, 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_access(1'b0, 2'b11, 3'b000, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1);
        run_access(1'b0, 2'b01, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0, 2);
        run_access(1'b1, 2'b00, 3'b000, 32'h0000_0302, 32'h0, 32'h12F0_3456, 4);
        run_access(1'b1, 2'b00, 3'b100, 32'h0000_0302, 32'h0, 32'h12F0_3456, 4);
        run_access(1'b1, 2'b00, 3'b101, 32'h0000_0302, 32'h0, 32'h12F0_3456, 2);
        run_access(1'b1, 2'b00, 3'b001, 32'h0000_0302, 32'h0, 32'h8001_0002, 1);
        run_access(1'b1, 2'b00, 3'b010, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 0);
        run_access(1'b1, 2'b00, 3'b010, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 3);
        run_access(1'b1, 2'b00, 3'b010, 32'h0000_0101, 32'h0, 32'h1234_5678, 1);
        run_access(1'b1, 2'b11, 3'b000, 32'h0000_0506, 32'h1122_3344, 32'h0, 1);

        // Reset in the middle of BUSY, followed by a late ack.
        @(posedge clk); #1;
        acc_valid = 1'b1; MemREAD = 1'b1; MemWrite = 2'b00; funct3 = 3'b010; addr = 32'h600;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; acc_valid = 1'b0; MemREAD = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_done", 32'(done), 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom);
            mw = 2'($urandom);
            if (!rd && mw == 2'b00) rd = 1'b1;
            run_access(rd, mw, f3_tab[$urandom_range(0, 5)], $urandom, $urandom, $urandom,
                       int'($urandom_range(0, TMO + 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit. It consumes the decoded memory controls carried down the pipeline (MemREAD, MemWrite size code, load funct3) and runs a req/ack transaction on the data-memory bus. It generates byte enables and lane-replicated store data, sign- or zero-extends load data, and stalls the pipeline until the access completes. It is the responder-side counterpart of the ID-stage memory control decode.

## Interface
- TIMEOUT_CYCLES, 255: BUSY cycles without mem_ack before the access is aborted with bus_err (legal range 1..65535).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- acc_valid  input  1  MEM-stage instruction is valid.
- MemREAD  input  1  load request.
- MemWrite  input  2  store size: WRITE_IDLE=00, WRITE_BYTE=01, WRITE_HALF=10, WRITE_WORD=11.
- funct3  input  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- addr  input  32  byte address from the ALU.
- store_data  input  32  rs2 value.
- stall  output  1  hold IF/ID/EX/MEM registers.
- done  output  1  one-cycle pulse: access finished.
- load_data  output  32  extended load result, valid while done=1.
- bus_err  output  1  valid with done; timeout occurred.
- misalign  output  1  valid with done; misaligned access trapped.
- mem_req  output  1  bus request.
- mem_we  output  1  1 = write.
- mem_be  output  4  byte enables.
- mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  output  32  lane-replicated store data.
- mem_rdata  input  32  read data, sampled when mem_ack=1.
- mem_ack  input  1  access complete.

## Operation
- start = acc_valid & (MemREAD | MemWrite!=00). MemREAD together with MemWrite!=00 is treated as a store.
- States: IDLE, BUSY, DONE.
- IDLE: on start, latch addr, size, funct3, store_data and we. Then go to BUSY, or to DONE if trapped misaligned. start is ignored in BUSY and DONE.
- BUSY: mem_req=1. mem_we, mem_be, mem_addr and mem_wdata stay stable. On mem_ack, capture mem_rdata and go to DONE. On timeout, go to DONE with bus_err=1.
- DONE: done=1 for one cycle, then return to IDLE.
- stall = (IDLE & start) | BUSY. stall is 0 in DONE so the pipeline advances at the end of DONE.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1],1'b0}
  - word: 1111
  - loads use the same mask as their size; LB/LBU are byte, LH/LHU are half, LW is word.
- mem_wdata: byte replicated ×4, half replicated ×2, word as-is.
- Load extraction: select the lane by addr[1:0] (half by addr[1]). LB/LH sign-extend, LBU/LHU zero-extend. Any other funct3 returns the word as LW.
- Timeout counter: 16-bit, cleared on entry to BUSY, increments each BUSY cycle without ack. When the count reaches TIMEOUT_CYCLES: mem_req drops, bus_err=1, load_data=0. An ack in the same cycle as the timeout wins.
- Stores: load_data=0 at done.

## Timing
- Reset: state IDLE, counter 0. mem_req, mem_we, mem_be, mem_addr, mem_wdata, done, load_data, bus_err, misalign are all 0.
- Cycle 0: start in IDLE; stall=1.
- Cycle 1..k: mem_req=1 (registered); ack in cycle k.
- Cycle k+1: DONE, done=1, stall=0. mem_req=0 from this cycle.
- Minimum latency: 3 cycles (ack in cycle 1). Stall length is k+1 cycles.
- mem_req never drops before ack or timeout.
- rst mid-transaction: abandon the access; mem_req=0 the next cycle. A late mem_ack in IDLE is ignored.
- An ack outside BUSY is ignored.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=00, issues no bus cycle.
  - The unit goes IDLE→DONE: stall=1 for cycle 0 only, then done=1, misalign=1, load_data=0.
- MEM_MISALIGN_TRAP_EN undefined:
  - misalign is tied to 0.
  - Misaligned accesses are issued with the low address bits ignored for lane selection: half uses addr[1], word uses full word.

## Test plan
- Word store, addr=0x100, data=0xDEADBEEF, ack in cycle 1 → mem_be=1111, mem_we=1, mem_addr=0x100; done at cycle 2; stall high for cycles 0–1.
- Byte store, addr=0x203, data=0x000000A5 → mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x200.
- LB, addr=0x302, rdata=0x12F03456, ack after 4 cycles → load_data=0xFFFFFFF0. Same access with LBU → 0x000000F0. LHU at addr=0x302 → 0x000012F0.
- TIMEOUT_CYCLES=4, never ack → mem_req high for 4 cycles; then done=1, bus_err=1, load_data=0. A subsequent access completes normally.
- rst asserted in BUSY, then ack one cycle later → mem_req=0 after rst; the ack is ignored; no done pulse.
- With MEM_MISALIGN_TRAP_EN defined: LW at addr=0x101 → no mem_req; done and misalign=1 in cycle 1. Without the macro: mem_req issued with mem_addr=0x100 and mem_be=1111.
